std_data_queue: RTL and testbench
=================================

STD_DATA_QUEUE -- requirements
Module: std_data_queue

Interface
REQ-001 SHALL have no parameters; depth is fixed at 16 entries, indexed by the 4-bit sqIdx value.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 io_in_valid  input  1  store-data writeback strobe from the store-data execution unit; no ready, always accepted.
REQ-005 io_in_bits_uop_ctrl_fuOpType  input  7  store op; bits[1:0] give size (0=B,1=H,2=W,3=D).
REQ-006 io_in_bits_uop_robIdx_flag / _value  input  1/5  ROB index of the store.
REQ-007 io_in_bits_uop_sqIdx_flag / _value  input  1/4  target store-queue entry.
REQ-008 io_in_bits_data  input  64  raw store data.
REQ-009 io_redirect_valid  input  1  flush request.
REQ-010 io_redirect_bits_robIdx_flag / _value  input  1/5  redirect point; strictly younger entries are killed.
REQ-011 io_deq_valid  output  1  head entry holds data.
REQ-012 io_deq_ready  input  1  consumer accepts head.
REQ-013 io_deq_bits_data  output  64  size-replicated head data.
REQ-014 io_deq_bits_sqIdx_flag / _value  output  1/4  current dequeue pointer.
REQ-015 io_count  output  5  number of valid entries, 0..16.

Function
REQ-016 Per entry: dataValid, sqFlag, robIdx (flag, value), size[1:0], data[63:0].
REQ-017 On io_in_valid, entry[sqIdx_value] SHALL take dataValid=1 and all fields on the next edge (1-cycle write-to-visible latency).
REQ-018 deqPtr (flag, value) SHALL advance by 1 on io_deq_valid & io_deq_ready; the value wraps 15->0 and the flag toggles on wrap.
REQ-019 io_deq_valid = dataValid[deqPtr.value] & (sqFlag[deqPtr.value] == deqPtr.flag).
REQ-020 io_deq_bits_data replication: B = byte0 x8, H = half0 x4, W = word0 x2, D = unchanged.
REQ-021 Dequeue handshake clears dataValid of the head entry.
REQ-022 isAfter(a,b) = (a.flag ^ b.flag) ^ (a.value > b.value).
REQ-023 On io_redirect_valid, every valid entry with isAfter(entry.robIdx, redirect.robIdx) SHALL be cleared on the next edge; an equal robIdx is kept.
REQ-024 In the same cycle as a redirect, a write whose robIdx is after the redirect point SHALL be dropped; an older write SHALL proceed.
REQ-025 Write and dequeue to the same entry in one cycle: the write wins and the entry stays valid with the new data.
REQ-026 A write to an already-valid entry SHALL overwrite it; io_count is unchanged.
REQ-027 io_count SHALL be a registered population count of dataValid, consistent with the state after each edge.
REQ-028 Dequeue and redirect in the same cycle: the dequeue takes effect, and the pointer advances even if the redirect would also clear the head.

Reset
REQ-029 While reset is low: deqPtr=0/flag 0, all dataValid=0, io_count=0, io_deq_valid=0; data/robIdx/size fields are not reset.
REQ-030 Reset asserted mid-operation SHALL discard all entries asynchronously; deassertion is synchronised externally.

Configuration
REQ-031 Macro STD_DATA_QUEUE_BYPASS_EN:
- Defined: an io_in write targeting deqPtr.value with matching flag, while the head is invalid, drives io_deq_valid and the replicated data in the same cycle. A handshake in that cycle consumes it; the entry is then not written valid.
- Undefined: the data appears one cycle after the write (REQ-017).

Verification
REQ-032 After reset, write sq 0/0 size D data 0x1122334455667788 -> next cycle deq_valid=1, data 0x1122334455667788, count=1; ready=1 -> count=0, deqPtr=1.
REQ-033 Write sq 0, size B, data 0xAB -> deq data 0xABABABABABABABAB; size H with 0x1234 -> 0x1234123412341234.
REQ-034 Fill all 16 entries, dequeue 16 -> count 16 then 0; deqPtr wraps to value 0, flag 1; a write with flag 0 at value 0 does not set deq_valid.
REQ-035 Entries robIdx 3,4,5 valid; redirect robIdx 4 -> only robIdx 5 cleared, count 3->2; a same-cycle write with robIdx 6 is dropped.
REQ-036 Head invalid, write to head with ready=1 -> BYPASS_EN: deq_valid same cycle, count stays 0; undefined: deq_valid next cycle.
REQ-037 Reset pulsed low with count=7 -> count=0 and deq_valid=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/std_data_queue.sv
// std_data_queue: 16-entry store-data queue indexed by sqIdx, drained in order via deqPtr.
// Optional same-cycle head bypass is enabled by defining STD_DATA_QUEUE_BYPASS_EN.
module std_data_queue (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_in_valid,
    input  logic [6:0]  io_in_bits_uop_ctrl_fuOpType,
    input  logic        io_in_bits_uop_robIdx_flag,
    input  logic [4:0]  io_in_bits_uop_robIdx_value,
    input  logic        io_in_bits_uop_sqIdx_flag,
    input  logic [3:0]  io_in_bits_uop_sqIdx_value,
    input  logic [63:0] io_in_bits_data,
    input  logic        io_redirect_valid,
    input  logic        io_redirect_bits_robIdx_flag,
    input  logic [4:0]  io_redirect_bits_robIdx_value,
    output logic        io_deq_valid,
    input  logic        io_deq_ready,
    output logic [63:0] io_deq_bits_data,
    output logic        io_deq_bits_sqIdx_flag,
    output logic [3:0]  io_deq_bits_sqIdx_value,
    output logic [4:0]  io_count
);
    localparam int DEPTH = 16;

    logic [15:0] valid_reg;
    logic [15:0] valid_next;
    logic [15:0] kill;
    logic [15:0] wr_hit;
    logic [15:0] deq_hit;
    logic [15:0] sq_flag_reg;
    logic [15:0] rob_flag_reg;
    logic [4:0]  rob_value_reg [DEPTH];
    logic [1:0]  size_reg [DEPTH];
    logic [63:0] data_reg [DEPTH];
    logic        deq_flag_reg;
    logic [3:0]  deq_value_reg;
    logic [4:0]  count_reg;

    logic [1:0]  in_size;
    logic        unused_op_bits;
    logic        write_drop;
    logic        write_en;
    logic        write_valid;
    logic        head_valid;
    logic        bypass_hit;
    logic        deq_fire;

    function automatic logic is_after(input logic a_flag, input logic [4:0] a_value,
                                      input logic b_flag, input logic [4:0] b_value);
        return (a_flag ^ b_flag) ^ (a_value > b_value);
    endfunction

    function automatic logic [63:0] replicate(input logic [1:0] size, input logic [63:0] d);
        case (size)
            2'd0:    return {8{d[7:0]}};
            2'd1:    return {4{d[15:0]}};
            2'd2:    return {2{d[31:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [4:0] popcount(input logic [15:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < DEPTH; i++) begin
            n = n + 5'(v[i]);
        end
        return n;
    endfunction

    assign in_size        = io_in_bits_uop_ctrl_fuOpType[1:0];
    assign unused_op_bits = ^io_in_bits_uop_ctrl_fuOpType[6:2];

    // A write younger than a concurrent redirect belongs to the flushed path.
    assign write_drop = io_redirect_valid &
                        is_after(io_in_bits_uop_robIdx_flag, io_in_bits_uop_robIdx_value,
                                 io_redirect_bits_robIdx_flag, io_redirect_bits_robIdx_value);
    assign write_en   = io_in_valid & ~write_drop;

    assign head_valid = valid_reg[deq_value_reg] & (sq_flag_reg[deq_value_reg] == deq_flag_reg);

`ifdef STD_DATA_QUEUE_BYPASS_EN
    assign bypass_hit = write_en & ~head_valid &
                        (io_in_bits_uop_sqIdx_value == deq_value_reg) &
                        (io_in_bits_uop_sqIdx_flag == deq_flag_reg);
`else
    assign bypass_hit = 1'b0;
`endif

    assign io_deq_valid     = head_valid | bypass_hit;
    assign io_deq_bits_data = bypass_hit ? replicate(in_size, io_in_bits_data)
                                         : replicate(size_reg[deq_value_reg], data_reg[deq_value_reg]);
    assign deq_fire         = io_deq_valid & io_deq_ready;
    // A bypassed write consumed by the handshake never occupies its entry.
    assign write_valid      = write_en & ~(bypass_hit & io_deq_ready);

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign kill[gi]    = io_redirect_valid & valid_reg[gi] &
                                 is_after(rob_flag_reg[gi], rob_value_reg[gi],
                                          io_redirect_bits_robIdx_flag, io_redirect_bits_robIdx_value);
            assign deq_hit[gi] = deq_fire & (deq_value_reg == 4'(gi));
            assign wr_hit[gi]  = write_valid & (io_in_bits_uop_sqIdx_value == 4'(gi));
            assign valid_next[gi] = wr_hit[gi] | (valid_reg[gi] & ~deq_hit[gi] & ~kill[gi]);
        end
    endgenerate

    // Payload fields carry no reset; only the valid bits gate their use.
    always_ff @(posedge clock) begin
        if (write_en) begin
            sq_flag_reg[io_in_bits_uop_sqIdx_value]   <= io_in_bits_uop_sqIdx_flag;
            rob_flag_reg[io_in_bits_uop_sqIdx_value]  <= io_in_bits_uop_robIdx_flag;
            rob_value_reg[io_in_bits_uop_sqIdx_value] <= io_in_bits_uop_robIdx_value;
            size_reg[io_in_bits_uop_sqIdx_value]      <= in_size;
            data_reg[io_in_bits_uop_sqIdx_value]      <= io_in_bits_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_reg     <= '0;
            deq_flag_reg  <= 1'b0;
            deq_value_reg <= 4'd0;
            count_reg     <= 5'd0;
        end else begin
            valid_reg <= valid_next;
            count_reg <= popcount(valid_next);
            if (deq_fire) begin
                {deq_flag_reg, deq_value_reg} <= {deq_flag_reg, deq_value_reg} + 5'd1;
            end
        end
    end

    assign io_deq_bits_sqIdx_flag  = deq_flag_reg;
    assign io_deq_bits_sqIdx_value = deq_value_reg;
    assign io_count                = count_reg;
endmodule

// File: tb/tb_std_data_queue.sv
// Directed testbench for std_data_queue; honours STD_DATA_QUEUE_BYPASS_EN for the head-bypass case.
module tb_std_data_queue;
    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [6:0]  fu_op;
    logic        in_rob_flag;
    logic [4:0]  in_rob_value;
    logic        in_sq_flag;
    logic [3:0]  in_sq_value;
    logic [63:0] in_data;
    logic        redir_valid;
    logic        redir_flag;
    logic [4:0]  redir_value;
    logic        deq_valid;
    logic        deq_ready;
    logic [63:0] deq_data;
    logic        deq_flag;
    logic [3:0]  deq_value;
    logic [4:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    std_data_queue dut (
        .clock                         (clock),
        .reset                         (reset),
        .io_in_valid                   (in_valid),
        .io_in_bits_uop_ctrl_fuOpType  (fu_op),
        .io_in_bits_uop_robIdx_flag    (in_rob_flag),
        .io_in_bits_uop_robIdx_value   (in_rob_value),
        .io_in_bits_uop_sqIdx_flag     (in_sq_flag),
        .io_in_bits_uop_sqIdx_value    (in_sq_value),
        .io_in_bits_data               (in_data),
        .io_redirect_valid             (redir_valid),
        .io_redirect_bits_robIdx_flag  (redir_flag),
        .io_redirect_bits_robIdx_value (redir_value),
        .io_deq_valid                  (deq_valid),
        .io_deq_ready                  (deq_ready),
        .io_deq_bits_data              (deq_data),
        .io_deq_bits_sqIdx_flag        (deq_flag),
        .io_deq_bits_sqIdx_value       (deq_value),
        .io_count                      (count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic set_write(input logic sqf, input logic [3:0] sqv, input logic rf,
                             input logic [4:0] rv, input logic [1:0] sz, input logic [63:0] d);
        in_valid     = 1'b1;
        in_sq_flag   = sqf;
        in_sq_value  = sqv;
        in_rob_flag  = rf;
        in_rob_value = rv;
        fu_op        = {5'b10100, sz};
        in_data      = d;
    endtask

    task automatic write_entry(input logic sqf, input logic [3:0] sqv, input logic rf,
                               input logic [4:0] rv, input logic [1:0] sz, input logic [63:0] d);
        set_write(sqf, sqv, rf, rv, sz, d);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic dequeue;
        deq_ready = 1'b1;
        tick();
        deq_ready = 1'b0;
    endtask

    task automatic do_reset;
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; fu_op = '0; in_rob_flag = 1'b0; in_rob_value = '0;
        in_sq_flag = 1'b0; in_sq_value = '0; in_data = '0; redir_valid = 1'b0;
        redir_flag = 1'b0; redir_value = '0; deq_ready = 1'b0;
        #2;
        check("rst_count", count, 0);
        check("rst_deq_valid", deq_valid, 0);
        check("rst_ptr", {deq_flag, deq_value}, 0);
        tick();
        tick();
        reset = 1'b1;

        // Basic write / dequeue with size D
        write_entry(0, 0, 0, 0, 3, 64'h1122334455667788);
        check("d_valid", deq_valid, 1);
        check("d_data", deq_data, 64'h1122334455667788);
        check("d_count", count, 1);
        dequeue();
        check("d_count_after", count, 0);
        check("d_ptr_after", {deq_flag, deq_value}, 5'h01);
        check("d_valid_after", deq_valid, 0);

        // Size replication
        write_entry(0, 1, 0, 1, 0, 64'hFFFF_FFFF_FFFF_FFAB);
        check("rep_b", deq_data, 64'hABABABABABABABAB);
        dequeue();
        write_entry(0, 2, 0, 2, 1, 64'h5555_5555_5555_1234);
        check("rep_h", deq_data, 64'h1234123412341234);
        dequeue();
        write_entry(0, 3, 0, 3, 2, 64'hDEADBEEF_CAFEF00D);
        check("rep_w", deq_data, 64'hCAFEF00DCAFEF00D);
        dequeue();
        check("rep_ptr", {deq_flag, deq_value}, 5'h04);

        // Fill all 16, drain 16, pointer wrap
        do_reset();
        for (int i = 0; i < 16; i++) begin
            write_entry(0, i[3:0], 0, 5'(i), 3, {32'hA5A50000, 32'(i)});
        end
        check("full_count", count, 16);
        for (int i = 0; i < 16; i++) begin
            check("drain_data", deq_data, {32'hA5A50000, 32'(i)});
            dequeue();
        end
        check("drain_count", count, 0);
        check("wrap_ptr", {deq_flag, deq_value}, 5'h10);
        write_entry(0, 0, 0, 0, 3, 64'h66);
        check("stale_flag_valid", deq_valid, 0);
        check("stale_flag_count", count, 1);
        write_entry(1, 0, 0, 0, 3, 64'h77);
        check("overwrite_valid", deq_valid, 1);
        check("overwrite_count", count, 1);
        check("overwrite_data", deq_data, 64'h77);
        dequeue();
        check("overwrite_ptr", {deq_flag, deq_value}, 5'h11);
        check("overwrite_count0", count, 0);

        // Write and dequeue hitting the same entry: write wins
        write_entry(1, 1, 0, 1, 3, 64'h1111);
        set_write(1, 1, 0, 1, 3, 64'h2222);
        deq_ready = 1'b1;
        tick();
        in_valid = 1'b0; deq_ready = 1'b0;
        check("wr_deq_count", count, 1);
        check("wr_deq_ptr", {deq_flag, deq_value}, 5'h12);

        // Redirect kills strictly younger entries and drops a younger write
        do_reset();
        write_entry(0, 0, 0, 3, 3, 64'h3);
        write_entry(0, 1, 0, 4, 3, 64'h4);
        write_entry(0, 2, 0, 5, 3, 64'h5);
        check("redir_pre_count", count, 3);
        redir_valid = 1'b1; redir_flag = 1'b0; redir_value = 5'd4;
        set_write(0, 3, 0, 6, 3, 64'h6);
        tick();
        in_valid = 1'b0; redir_valid = 1'b0;
        check("redir_count", count, 2);
        check("redir_head0", deq_data, 64'h3);
        dequeue();
        check("redir_head1", deq_data, 64'h4);
        dequeue();
        check("redir_killed_head", deq_valid, 0);
        check("redir_drained", count, 0);

        // Flag-wrapped robIdx comparison; older same-cycle write proceeds
        write_entry(0, 2, 1, 1, 3, 64'h21);
        write_entry(0, 3, 0, 29, 3, 64'h29);
        check("redir2_pre", count, 2);
        redir_valid = 1'b1; redir_flag = 1'b0; redir_value = 5'd30;
        set_write(0, 4, 0, 10, 3, 64'h10);
        tick();
        in_valid = 1'b0; redir_valid = 1'b0;
        check("redir2_count", count, 2);
        check("redir2_head", deq_valid, 0);

        // Dequeue and redirect killing the head in the same cycle
        do_reset();
        write_entry(0, 0, 0, 5, 3, 64'h5555);
        redir_valid = 1'b1; redir_flag = 1'b0; redir_value = 5'd4;
        deq_ready = 1'b1;
        #1;
        check("deq_redir_valid", deq_valid, 1);
        check("deq_redir_data", deq_data, 64'h5555);
        tick();
        redir_valid = 1'b0; deq_ready = 1'b0;
        check("deq_redir_ptr", {deq_flag, deq_value}, 5'h01);
        check("deq_redir_count", count, 0);

        // Write to an empty head with the consumer ready
        set_write(0, 1, 0, 1, 3, 64'h3636);
        deq_ready = 1'b1;
        #1;
`ifdef STD_DATA_QUEUE_BYPASS_EN
        check("byp_valid", deq_valid, 1);
        check("byp_data", deq_data, 64'h3636);
        tick();
        in_valid = 1'b0; deq_ready = 1'b0;
        check("byp_count", count, 0);
        check("byp_ptr", {deq_flag, deq_value}, 5'h02);
`else
        check("nobyp_valid", deq_valid, 0);
        tick();
        in_valid = 1'b0; deq_ready = 1'b0;
        check("nobyp_valid_next", deq_valid, 1);
        check("nobyp_count", count, 1);
        check("nobyp_ptr", {deq_flag, deq_value}, 5'h01);
`endif

        // Asynchronous reset in mid-cycle
        do_reset();
        for (int i = 0; i < 7; i++) begin
            write_entry(0, i[3:0], 0, 5'(i), 3, 64'(i));
        end
        check("areset_pre", count, 7);
        #2;
        reset = 1'b0;
        #1;
        check("areset_count", count, 0);
        check("areset_valid", deq_valid, 0);
        tick();
        reset = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
